// File: rtl/key_code_note_decoder.sv
// key_code_note_decoder
//   Consumer end of the synthesizer key_code stream. Debounces the 8-bit
//   scan-code level, tracks the currently held note, measures note length in
//   clock cycles and emits note-on/note-off events through a 2-deep
//   first-word-fallthrough queue.
//
// Optional feature macro: KEYDEC_AUTO_RELEASE_EN
//   Defined   : a note held for MAX_HOLD cycles is released automatically.
//   Undefined : notes end only on a release code (8'hF0) or a legato change.
//
// Ports
//   clock       in   system clock, rising edge
//   k_tr        in   asynchronous active-low reset
//   key_code    in   scan-code level, 8'hF0 = release
//   ev_ready    in   downstream accepts the head event
//   ev_valid    out  queue head is valid
//   ev_type     out  1 = note-on, 0 = note-off
//   ev_note     out  note index 1..8
//   ev_dur      out  length of the ended note (note-off), 0 for note-on
//   note_active out  a note is currently held (FSM is in HELD)
//   cur_note    out  held note index, 0 when idle
//   unknown     out  one-cycle pulse when an unmapped, non-F0 code is accepted
//   ovf         out  sticky, an event was dropped because the queue was full
//
// Handshake: the head event transfers on any rising edge where ev_valid and
// ev_ready are both high; ev_valid never depends on ev_ready, and the head
// fields stay stable while ev_valid is high and ev_ready is low.
module key_code_note_decoder #(
    parameter int unsigned      STABLE_CYCLES = 4,
    parameter int unsigned      DUR_W         = 16,
    parameter logic [DUR_W-1:0] MAX_HOLD      = 'h0400
) (
    input  logic             clock,
    input  logic             k_tr,
    input  logic [7:0]       key_code,
    input  logic             ev_ready,
    output logic             ev_valid,
    output logic             ev_type,
    output logic [3:0]       ev_note,
    output logic [DUR_W-1:0] ev_dur,
    output logic             note_active,
    output logic [3:0]       cur_note,
    output logic             unknown,
    output logic             ovf
);

    localparam logic [7:0] REL_CODE   = 8'hF0;
    localparam logic [7:0] STABLE_CNT = STABLE_CYCLES[7:0];
    localparam int         EW         = DUR_W + 5;

    typedef enum logic {IDLE, HELD} state_t;

    // Note index for a scan code; 0 means unmapped (or the release code).
    function automatic logic [3:0] map_code(input logic [7:0] c);
        case (c)
            8'h2B:   return 4'd1;
            8'h34:   return 4'd2;
            8'h33:   return 4'd3;
            8'h3B:   return 4'd4;
            8'h42:   return 4'd5;
            8'h4B:   return 4'd6;
            8'h4C:   return 4'd7;
            8'h52:   return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [EW-1:0] mk_ev(input logic typ, input logic [3:0] note,
                                            input logic [DUR_W-1:0] d);
        return {typ, note, d};
    endfunction

    // ---------------- input filter ----------------
    logic [7:0] cand;
    logic [7:0] stab_cnt;
    logic [7:0] acc_code;
    logic       accept;

    // The count is registered, so a code is taken on the edge after it has
    // been sampled STABLE_CYCLES times in a row.
    assign accept = (stab_cnt >= STABLE_CNT) && (cand != acc_code);

    always_ff @(posedge clock or negedge k_tr) begin
        if (!k_tr) begin
            cand     <= REL_CODE;
            stab_cnt <= 8'd0;
            acc_code <= REL_CODE;
        end else begin
            if (key_code != cand) begin
                cand     <= key_code;
                stab_cnt <= 8'd1;
            end else if (stab_cnt != 8'hFF) begin
                stab_cnt <= stab_cnt + 8'd1;
            end
            if (accept) begin
                acc_code <= cand;
            end
        end
    end

    // ---------------- note FSM ----------------
    state_t           state, state_n;
    logic [3:0]       cur_n;
    logic [DUR_W-1:0] dur, dur_n, dur_inc;
    logic             push0_v, push1_v;
    logic [EW-1:0]    push0_d, push1_d;
    logic             unk_n;
    logic             note_evt;
    logic [3:0]       acc_note;

    assign acc_note = map_code(cand);
    // Elapsed cycles including the current edge, so ev_dur equals the
    // distance between the two accept edges.
    assign dur_inc  = (dur == '1) ? dur : dur + DUR_W'(1);

    always_comb begin
        state_n  = state;
        cur_n    = cur_note;
        dur_n    = (state == HELD) ? dur_inc : dur;
        push0_v  = 1'b0;
        push0_d  = '0;
        push1_v  = 1'b0;
        push1_d  = '0;
        unk_n    = 1'b0;
        note_evt = 1'b0;
        if (accept) begin
            if (cand == REL_CODE) begin
                if (state == HELD) begin
                    push0_v  = 1'b1;
                    push0_d  = mk_ev(1'b0, cur_note, dur_inc);
                    state_n  = IDLE;
                    cur_n    = 4'd0;
                    note_evt = 1'b1;
                end
            end else if (acc_note != 4'd0) begin
                if (state == IDLE) begin
                    push0_v  = 1'b1;
                    push0_d  = mk_ev(1'b1, acc_note, '0);
                    state_n  = HELD;
                    cur_n    = acc_note;
                    dur_n    = '0;
                    note_evt = 1'b1;
                end else if (acc_note != cur_note) begin
                    // Legato: off for the old note strictly before on for the new.
                    push0_v  = 1'b1;
                    push0_d  = mk_ev(1'b0, cur_note, dur_inc);
                    push1_v  = 1'b1;
                    push1_d  = mk_ev(1'b1, acc_note, '0);
                    cur_n    = acc_note;
                    dur_n    = '0;
                    note_evt = 1'b1;
                end
            end else begin
                unk_n = 1'b1;
            end
        end
`ifdef KEYDEC_AUTO_RELEASE_EN
        // Accepted code is left alone, so a later F0 finds IDLE and is ignored.
        if ((state == HELD) && !note_evt && (dur_inc == MAX_HOLD)) begin
            push0_v = 1'b1;
            push0_d = mk_ev(1'b0, cur_note, MAX_HOLD);
            state_n = IDLE;
            cur_n   = 4'd0;
        end
`else
        note_evt = note_evt;
`endif
    end

`ifndef KEYDEC_AUTO_RELEASE_EN
    logic unused_max_hold;
    assign unused_max_hold = ^MAX_HOLD;
`endif

    always_ff @(posedge clock or negedge k_tr) begin
        if (!k_tr) begin
            state    <= IDLE;
            cur_note <= 4'd0;
            dur      <= '0;
            unknown  <= 1'b0;
        end else begin
            state    <= state_n;
            cur_note <= cur_n;
            dur      <= dur_n;
            unknown  <= unk_n;
        end
    end

    assign note_active = (state == HELD);

    // ---------------- 2-entry FWFT queue ----------------
    logic [EW-1:0] mem [2];
    logic          rp, wp;
    logic [1:0]    q_cnt, cnt_after_pop;
    logic          pop, fit0, fit1, drop;
    logic [EW-1:0] head;

    assign pop           = ev_valid && ev_ready;
    assign cnt_after_pop = q_cnt - {1'b0, pop};
    // Pushes are taken in order; whatever no longer fits is dropped.
    assign fit0          = push0_v && (cnt_after_pop < 2'd2);
    assign fit1          = push1_v && ((cnt_after_pop + {1'b0, fit0}) < 2'd2);
    assign drop          = (push0_v && !fit0) || (push1_v && !fit1);

    always_ff @(posedge clock or negedge k_tr) begin
        if (!k_tr) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rp     <= 1'b0;
            wp     <= 1'b0;
            q_cnt  <= 2'd0;
            ovf    <= 1'b0;
        end else begin
            if (fit0) begin
                mem[wp] <= push0_d;
            end
            if (fit1) begin
                mem[~wp] <= push1_d;
            end
            wp    <= wp ^ (fit0 ^ fit1);
            rp    <= rp ^ pop;
            q_cnt <= cnt_after_pop + {1'b0, fit0} + {1'b0, fit1};
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    assign head     = mem[rp];
    assign ev_valid = (q_cnt != 2'd0);
    assign ev_type  = ev_valid & head[EW-1];
    assign ev_note  = ev_valid ? head[EW-2:DUR_W] : 4'd0;
    assign ev_dur   = ev_valid ? head[DUR_W-1:0] : '0;

endmodule

// File: tb/tb_key_code_note_decoder.sv
module tb_key_code_note_decoder;

  localparam int S        = 4;
  localparam int MAX_HOLD = 16;

  logic        clock;
  logic        k_tr;
  logic [7:0]  key_code;
  logic        ev_ready;
  logic        ev_valid;
  logic        ev_type;
  logic [3:0]  ev_note;
  logic [15:0] ev_dur;
  logic        note_active;
  logic [3:0]  cur_note;
  logic        unknown;
  logic        ovf;

  key_code_note_decoder #(
    .STABLE_CYCLES(S),
    .DUR_W(16),
    .MAX_HOLD(16'(MAX_HOLD))
  ) dut (
    .clock(clock),
    .k_tr(k_tr),
    .key_code(key_code),
    .ev_ready(ev_ready),
    .ev_valid(ev_valid),
    .ev_type(ev_type),
    .ev_note(ev_note),
    .ev_dur(ev_dur),
    .note_active(note_active),
    .cur_note(cur_note),
    .unknown(unknown),
    .ovf(ovf)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        typ;
    logic [3:0]  note;
    logic [15:0] dur;
  } ev_t;

  logic [7:0] note_codes [8] = '{8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C, 8'h52};

  logic [7:0] hist [$];   // most recent key_code samples, oldest first
  ev_t        mq [$];     // expected queue contents, head first
  logic [7:0] m_acc;
  bit         m_held;
  int         m_cur;
  int         m_start;
  int         cyc;
  bit         m_ovf;
  bit         m_unknown;

  function automatic int note_of(input logic [7:0] c);
    for (int i = 0; i < 8; i++)
      if (note_codes[i] == c) return i + 1;
    return 0;
  endfunction

  function automatic logic [15:0] elapsed();
    int d;
    d = cyc - m_start;
    if (d > 65535) d = 65535;
    return 16'(d);
  endfunction

  task automatic model_reset();
    hist.delete();
    mq.delete();
    m_acc     = 8'hF0;
    m_held    = 0;
    m_cur     = 0;
    m_start   = 0;
    m_ovf     = 0;
    m_unknown = 0;
  endtask

  task automatic model_edge();
    ev_t  pend [$];
    ev_t  e;
    bit   take;
    bit   pop;
    bit   ended;
    int   n;
    logic [7:0] v;
    pop = (mq.size() != 0) && ev_ready;
    cyc++;
    m_unknown = 0;
    ended = 0;
    // A value is taken once the last S samples all agree and differ from
    // the currently accepted code.
    take = 0;
    if (hist.size() == S) begin
      take = 1;
      foreach (hist[i]) if (hist[i] != hist[0]) take = 0;
      if (hist[0] == m_acc) take = 0;
    end
    if (take) begin
      v = hist[0];
      m_acc = v;
      n = note_of(v);
      if (v == 8'hF0) begin
        if (m_held) begin
          e.typ = 0; e.note = 4'(m_cur); e.dur = elapsed();
          pend.push_back(e);
          m_held = 0; m_cur = 0; ended = 1;
        end
      end else if (n != 0) begin
        if (!m_held) begin
          e.typ = 1; e.note = 4'(n); e.dur = 0;
          pend.push_back(e);
          m_held = 1; m_cur = n; m_start = cyc; ended = 1;
        end else if (n != m_cur) begin
          e.typ = 0; e.note = 4'(m_cur); e.dur = elapsed();
          pend.push_back(e);
          e.typ = 1; e.note = 4'(n); e.dur = 0;
          pend.push_back(e);
          m_cur = n; m_start = cyc; ended = 1;
        end
      end else begin
        m_unknown = 1;
      end
    end
`ifdef KEYDEC_AUTO_RELEASE_EN
    if (m_held && !ended && (cyc - m_start == MAX_HOLD)) begin
      e.typ = 0; e.note = 4'(m_cur); e.dur = 16'(MAX_HOLD);
      pend.push_back(e);
      m_held = 0; m_cur = 0;
    end
`endif
    if (pop) void'(mq.pop_front());
    foreach (pend[i]) begin
      if (mq.size() < 2) mq.push_back(pend[i]);
      else m_ovf = 1;
    end
    hist.push_back(key_code);
    if (hist.size() > S) void'(hist.pop_front());
  endtask

  always @(posedge clock or negedge k_tr) begin
    if (!k_tr) model_reset();
    else model_edge();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    chk("ev_valid", ev_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("ev_type", ev_type, mq[0].typ);
      chk("ev_note", ev_note, mq[0].note);
      chk("ev_dur", ev_dur, mq[0].dur);
    end else begin
      chk("ev_type_idle", ev_type, 0);
      chk("ev_note_idle", ev_note, 0);
      chk("ev_dur_idle", ev_dur, 0);
    end
    chk("note_active", note_active, m_held);
    chk("cur_note", cur_note, m_cur);
    chk("unknown", unknown, m_unknown);
    chk("ovf", ovf, m_ovf);
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input logic [7:0] code, input int n);
    key_code = code;
    repeat (n) @(negedge clock);
  endtask

  task automatic hold_rand(input logic [7:0] code, input int n);
    key_code = code;
    repeat (n) begin
      ev_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
    end
  endtask

  logic [7:0] pool [14] = '{8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C, 8'h52,
                            8'hF0, 8'hF0, 8'hF0, 8'h5A, 8'h00, 8'h1C};

  // ---------------- stimulus ----------------
  initial begin
    cyc      = 0;
    k_tr     = 1'b0;
    key_code = 8'hF0;
    ev_ready = 1'b0;
    repeat (3) @(negedge clock);
    #2 k_tr = 1'b1;

    // Idle after reset with F0 on the bus.
    hold(8'hF0, 20);
    chk("t1_valid", ev_valid, 0);
    chk("t1_active", note_active, 0);
    chk("t1_ovf", ovf, 0);

    // Simple note: on(1) four clocks after the change, off(1, 10).
    ev_ready = 1'b1;
    hold(8'h2B, 4);
    chk("t2_pre_valid", ev_valid, 0);
    @(negedge clock);
    chk("t2_on_valid", ev_valid, 1);
    chk("t2_on_type", ev_type, 1);
    chk("t2_on_note", ev_note, 1);
    chk("t2_cur_on", cur_note, 1);
    repeat (5) @(negedge clock);
    hold(8'hF0, 5);
    chk("t2_off_valid", ev_valid, 1);
    chk("t2_off_type", ev_type, 0);
    chk("t2_off_note", ev_note, 1);
    chk("t2_off_dur", ev_dur, 10);
    chk("t2_cur_off", cur_note, 0);
    hold(8'hF0, 4);

    // Glitch shorter than the filter, then an unmapped code.
    hold(8'h34, 3);
    hold(8'hF0, 8);
    chk("t3_glitch_valid", ev_valid, 0);
    chk("t3_glitch_active", note_active, 0);
    hold(8'h5A, 4);
    key_code = 8'hF0;
    chk("t3_unk_before", unknown, 0);
    @(negedge clock);
    chk("t3_unk_pulse", unknown, 1);
    @(negedge clock);
    chk("t3_unk_after", unknown, 0);
    hold(8'hF0, 8);
    chk("t3_unk_valid", ev_valid, 0);

    // Legato: off(3, 8) then on(4) on consecutive pop cycles.
    hold(8'h33, 5);
    chk("t4_on3_note", ev_note, 3);
    repeat (3) @(negedge clock);
    hold(8'h3B, 5);
    chk("t4_off_type", ev_type, 0);
    chk("t4_off_note", ev_note, 3);
    chk("t4_off_dur", ev_dur, 8);
    chk("t4_active_a", note_active, 1);
    @(negedge clock);
    chk("t4_on4_type", ev_type, 1);
    chk("t4_on4_note", ev_note, 4);
    chk("t4_active_b", note_active, 1);
    hold(8'hF0, 10);

    // Overflow with a stalled consumer, then drain and reset mid-note.
    ev_ready = 1'b0;
    hold(8'h2B, 6);
    hold(8'hF0, 6);
    hold(8'h34, 8);
    chk("t5_ovf", ovf, 1);
    chk("t5_head_type", ev_type, 1);
    chk("t5_head_note", ev_note, 1);
    chk("t5_cur", cur_note, 2);
    ev_ready = 1'b1;
    @(negedge clock);
    chk("t5_off_type", ev_type, 0);
    chk("t5_off_dur", ev_dur, 6);
    @(negedge clock);
    chk("t5_drained", ev_valid, 0);
    #2 k_tr = 1'b0;
    #1;
    chk("t5_rst_ovf", ovf, 0);
    chk("t5_rst_active", note_active, 0);
    chk("t5_rst_cur", cur_note, 0);
    chk("t5_rst_valid", ev_valid, 0);
    key_code = 8'hF0;
    repeat (2) @(negedge clock);
    #2 k_tr = 1'b1;
    hold(8'hF0, 5);

    // Long hold: auto-release when built with the feature.
    hold(8'h42, 5);
    chk("t6_on_note", ev_note, 5);
    repeat (16) @(negedge clock);
`ifdef KEYDEC_AUTO_RELEASE_EN
    chk("t6_auto_type", ev_type, 0);
    chk("t6_auto_note", ev_note, 5);
    chk("t6_auto_dur", ev_dur, MAX_HOLD);
    chk("t6_auto_active", note_active, 0);
`else
    chk("t6_still_held", note_active, 1);
`endif
    repeat (19) @(negedge clock);
    hold(8'hF0, 10);
    chk("t6_end_valid", ev_valid, 0);

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 500; i++) begin
      if (i == 250) begin
        #2 k_tr = 1'b0;
        @(negedge clock);
        #2 k_tr = 1'b1;
      end
      if (i % 40 == 0) hold_rand(pool[$urandom_range(0, 7)], 30);
      else hold_rand(pool[$urandom_range(0, 13)], $urandom_range(1, 10));
    end
    ev_ready = 1'b1;
    hold(8'hF0, 10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
